// File: rtl/t08_alu_mdu.sv
// t08_alu_mdu: single-cycle integer ALU plus a WIDTH-cycle radix-2 multiply/divide unit.
//   clk, nRst            clock, asynchronous active-low reset
//   start, flush         request (taken only while busy=0), synchronous abort
//   alu_control          op code: 1-35 base ops, 36-43 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   reg1, reg2           register operands
//   immediate            immediate operand
//   program_counter      program counter, used by AUIPC
//   busy                 multiply/divide in flight
//   done                 one-cycle completion pulse
//   data_out, branch     result and branch decision, held until the next done
module t08_alu_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             start,
   input  logic             flush,
   input  logic [5:0]       alu_control,
   input  logic [WIDTH-1:0] reg1,
   input  logic [WIDTH-1:0] reg2,
   input  logic [WIDTH-1:0] immediate,
   input  logic [WIDTH-1:0] program_counter,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             branch
);
   localparam int unsigned SW      = $clog2(WIDTH);
   localparam logic [SW:0] CntLast = (SW+1)'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, branch_q, branch_d, neg_q, neg_d;
   logic [WIDTH-1:0] data_q, data_d, hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic [5:0]       op_q, op_d;
   logic [SW:0]      cnt_q, cnt_d;

   // Single-cycle ALU
   logic [WIDTH-1:0] opb, alu_res;
   logic [SW-1:0]    shamt;
   logic             alu_br;

   always_comb begin
      opb     = (alu_control inside {[6'd11:6'd19]}) ? immediate : reg2;
      shamt   = opb[SW-1:0];
      alu_res = '0;
      alu_br  = 1'b0;
      case (alu_control)
         6'd1, 6'd11:  alu_res = reg1 + opb;
         6'd2:         alu_res = reg1 - opb;
         6'd3, 6'd17:  alu_res = reg1 << shamt;
         6'd4, 6'd12:  alu_res = {{(WIDTH-1){1'b0}}, $signed(reg1) < $signed(opb)};
         6'd5, 6'd13:  alu_res = {{(WIDTH-1){1'b0}}, reg1 < opb};
         6'd6, 6'd14:  alu_res = reg1 ^ opb;
         6'd7, 6'd18:  alu_res = reg1 >> shamt;
         6'd8, 6'd19:  alu_res = $signed(reg1) >>> shamt;
         6'd9, 6'd15:  alu_res = reg1 | opb;
         6'd10, 6'd16: alu_res = reg1 & opb;
         6'd20, 6'd21, 6'd22, 6'd23,
         6'd24, 6'd25, 6'd26, 6'd27: alu_res = reg1 + immediate;
         6'd28: alu_br = (reg1 == reg2);
         6'd29: alu_br = (reg1 != reg2);
         6'd30: alu_br = ($signed(reg1) < $signed(reg2));
         6'd31: alu_br = ($signed(reg1) >= $signed(reg2));
         6'd32: alu_br = (reg1 < reg2);
         6'd33: alu_br = (reg1 >= reg2);
         6'd35: alu_res = program_counter + immediate;
         default: ;
      endcase
   end

   // Operand capture: the iterative core works on magnitudes, neg records the final sign fix
   logic             is_mdu, a_sgn, b_sgn, a_neg, b_neg, req_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      is_mdu = alu_control inside {[6'd36:6'd43]};
      a_sgn  = alu_control inside {6'd36, 6'd37, 6'd38, 6'd40, 6'd42};
      b_sgn  = alu_control inside {6'd36, 6'd37, 6'd40, 6'd42};
      a_neg  = a_sgn & reg1[WIDTH-1];
      b_neg  = b_sgn & reg2[WIDTH-1];
      a_mag  = a_neg ? -reg1 : reg1;
      b_mag  = b_neg ? -reg2 : reg2;
      case (alu_control)
         // Divide by zero keeps the all-ones quotient positive
         6'd40:        req_neg = (a_neg ^ b_neg) & (|reg2);
         6'd41, 6'd43: req_neg = 1'b0;
         6'd42:        req_neg = a_neg;
         default:      req_neg = a_neg ^ b_neg;
      endcase
   end

   // Iteration datapath. Multiply: {hi,lo} is the shift-add product, lo starts as the
   // multiplier. Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_sub, quo_fix, rem_fix, fix_res;
   logic [2*WIDTH-1:0] prod_fix;

   always_comb begin
      mul_sum  = {1'b0, hi_q} + {1'b0, lo_q[0] ? m_q : '0};
      rem_sh   = {hi_q, lo_q[WIDTH-1]};
      rem_ge   = rem_sh >= {1'b0, m_q};
      rem_sub  = rem_sh[WIDTH-1:0] - m_q;
      prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo_fix  = neg_q ? -lo_q : lo_q;
      rem_fix  = neg_q ? -hi_q : hi_q;
      case (op_q)
         6'd36:               fix_res = prod_fix[WIDTH-1:0];
         6'd37, 6'd38, 6'd39: fix_res = prod_fix[2*WIDTH-1:WIDTH];
         6'd40, 6'd41:        fix_res = quo_fix;
         default:             fix_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      data_d   = data_q;
      branch_d = branch_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      m_d      = m_q;
      op_d     = op_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               state_d = StIdle;
               if (start && is_mdu) begin
                  state_d = StCalc;
                  op_d    = alu_control;
                  neg_d   = req_neg;
                  cnt_d   = '0;
                  hi_d    = '0;
                  // op 36-39 multiply (multiplier in lo), 40-43 divide (dividend in lo)
                  lo_d    = alu_control[3] ? a_mag : b_mag;
                  m_d     = alu_control[3] ? b_mag : a_mag;
               end else if (start) begin
                  data_d   = alu_res;
                  branch_d = alu_br;
                  done_d   = 1'b1;
               end
            end
            StCalc: begin
               if (op_q[3]) begin
                  hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], rem_ge};
               end else begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntLast) state_d = StFix;
            end
            StFix: begin
               data_d   = fix_res;
               branch_d = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end
            default: state_d = StIdle;
         endcase
      end
      busy_d = (state_d == StCalc) || (state_d == StFix);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
         branch_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         data_q   <= data_d;
         branch_q <= branch_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         m_q      <= m_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_q;
   assign branch   = branch_q;

endmodule

// File: doc/t08_alu_mdu.md
T08_ALU_MDU -- requirements
Module: t08_alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; legal values 8..64, even.
REQ-002 SHALL use SW = $clog2(WIDTH), the shift-amount width (5 at default).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port nRst, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request; sampled only when busy=0.
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-007 SHALL have port alu_control, input, 6 bits: operation code, sampled with start.
REQ-008 SHALL have ports reg1, reg2, immediate, program_counter, each input, WIDTH bits: operands, sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: a multi-cycle operation is in flight.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; data_out and branch are valid for the completed request.
REQ-011 SHALL have port data_out, output, WIDTH bits: result, held until the next done.
REQ-012 SHALL have port branch, output, 1 bit: branch decision, held until the next done.

Function
REQ-013 Base op codes SHALL be unchanged:
- 1-10: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (reg1 op reg2).
- 11-19: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (reg1 op immediate).
- 20-27: loads and stores; result = reg1+immediate.
- 28-33: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- 35: AUIPC; result = program_counter+immediate.
REQ-014 New op codes SHALL be 36 MUL, 37 MULH, 38 MULHSU, 39 MULHU, 40 DIV, 41 DIVU, 42 REM, 43 REMU, with RV32M semantics generalised to WIDTH.
REQ-015 Shifts SHALL use only the low SW bits of the shift operand; SRA and SRAI SHALL sign-fill.
REQ-016 Single-cycle ops (all codes except 36-43) accepted at edge E SHALL:
- drive done=1 during the cycle after E;
- register data_out and branch at E;
- leave busy at 0.
REQ-017 Branch ops SHALL set branch to the compare result and data_out=0; all other ops SHALL set branch=0.
REQ-018 Undefined codes (0, 34, 44-63) SHALL complete as single-cycle ops with data_out=0 and branch=0.
REQ-019 FSM states SHALL be IDLE, CALC, FIX, DONE.
- IDLE -> CALC on start with a code in 36-43; busy=1 from the next cycle.
- CALC: one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes) for exactly WIDTH cycles, counted by an SW+1-bit counter.
- CALC -> FIX: FIX applies sign correction and special cases and registers data_out.
- FIX -> DONE: DONE drives done=1 and busy=0; DONE -> IDLE.
REQ-020 Multi-cycle latency SHALL be fixed: done high exactly WIDTH+2 cycles after the accepting edge, independent of operand values.
REQ-021 MUL SHALL return the low WIDTH bits of the 2*WIDTH-bit product; MULH, MULHSU and MULHU SHALL return the high WIDTH bits (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-022 Divide by zero SHALL give DIV/DIVU quotient = all ones and REM/REMU = reg1.
REQ-023 Signed overflow (reg1 = most-negative, reg2 = -1) SHALL give DIV = reg1 and REM = 0.
REQ-024 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-025 Busy handling:
- start while busy=1 SHALL be ignored, with no queuing;
- start in the DONE cycle SHALL be accepted (busy is 0 there).
REQ-026 Flush:
- flush=1 SHALL return the FSM to IDLE at the next edge with no done pulse, leaving data_out and branch unchanged;
- flush has priority over a same-cycle start.
REQ-027 Operands SHALL be captured internally at acceptance; later input changes SHALL NOT affect the result.

Reset
REQ-028 nRst=0 SHALL immediately force state IDLE, busy=0, done=0, data_out=0, branch=0, and clear the counter and internal operand registers, including mid-CALC.
REQ-029 After nRst deasserts, the first rising edge SHALL be able to accept start.

Verification (WIDTH=32)
REQ-030 Base sweep: reg1=-500, reg2=200, imm=300, pc=0, codes 1-35 -> each done one cycle later, e.g. ADD=-300, SLT=1, BLT branch=1, SRA by 8 = -2.
REQ-031 MULH with reg1=0x80000000, reg2=0x80000000 -> 0x40000000 after 34 cycles; MULHU on the same operands -> 0x40000000; MUL -> 0.
REQ-032 DIV -7/2 -> -3; REM -7/2 -> -1; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000 with REM 0.
REQ-033 Busy/flush: start DIVU, assert start again at cycle 5 -> ignored; flush at cycle 10 -> IDLE, no done, data_out keeps its previous value.
REQ-034 Reset mid-op: nRst=0 at cycle 12 of MUL -> busy, done and data_out are 0 asynchronously; next start ADD 3+4 -> 7.
REQ-035 Back-to-back: start MUL 6*7 and start ADD in its DONE cycle -> done=42, then done=ADD result one cycle later.
